// File: rtl/timer_setter.sv
// timer_setter: debounced increase key steps the hours/minutes reminder threshold in set mode.
// Optional auto-repeat while held: define TIMER_SETTER_AUTO_REPEAT_EN.
module timer_setter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEFAULT_HOURS   = 10,
  parameter int DEFAULT_MINUTES = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mode,
  input  logic       set_select,
  input  logic       increase_key,
  input  logic       visible,
  output logic [4:0] hours,
  output logic [5:0] minutes
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1, sync2, stable, stable_last, press, en, bump;
  logic [CW-1:0] cnt;
  assign press = stable & ~stable_last;
  assign en = set_mode & visible;
`ifdef TIMER_SETTER_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rpt_cnt;
  logic rpt_active, rpt_first, rpt_fire;
  // rpt_cnt holds the number of edges elapsed since the last increment
  assign rpt_fire = rpt_active & stable & en &
                    (rpt_cnt == (rpt_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));
  assign bump = (press & en) | rpt_fire;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_active <= 1'b0;
      rpt_first  <= 1'b0;
      rpt_cnt    <= '0;
    end else if (!(stable & en)) begin
      rpt_active <= 1'b0;
      rpt_cnt    <= '0;
    end else if (press) begin
      rpt_active <= 1'b1;
      rpt_first  <= 1'b1;
      rpt_cnt    <= RW'(1);
    end else if (rpt_fire) begin
      rpt_first <= 1'b0;
      rpt_cnt   <= RW'(1);
    end else if (rpt_active) begin
      rpt_cnt <= rpt_cnt + RW'(1);
    end
  end
`else
  assign bump = press & en;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      stable_last <= 1'b0;
      cnt         <= '0;
      hours       <= 5'(DEFAULT_HOURS);
      minutes     <= 6'(DEFAULT_MINUTES);
    end else begin
      sync1       <= increase_key;
      sync2       <= sync1;
      stable_last <= stable;
      if (sync2 == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else cnt <= cnt + CW'(1);
      if (bump && set_select) hours <= (hours == 5'd23) ? 5'd0 : hours + 5'd1;
      if (bump && !set_select) minutes <= (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    end
  end
endmodule

// File: tb/tb_timer_setter.sv
// tb_timer_setter: directed checks of debounce, field stepping, wrap, gating and optional auto-repeat.
module tb_timer_setter;
  logic clk = 1'b0, reset = 1'b1, set_mode = 1'b0, set_select = 1'b0, increase_key = 1'b0, visible = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  int total = 0, fails = 0;

  timer_setter #(.DEBOUNCE_CYCLES(4), .DEFAULT_HOURS(10), .DEFAULT_MINUTES(0),
                 .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .reset(reset), .set_mode(set_mode), .set_select(set_select),
    .increase_key(increase_key), .visible(visible), .hours(hours), .minutes(minutes));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int hold);
    increase_key = 1'b1;
    tick(hold);
    increase_key = 1'b0;
    tick(8);
  endtask

  initial begin
    tick(3);
    check("reset_hours", 32'(hours), 10);
    check("reset_minutes", 32'(minutes), 0);
    reset = 1'b0;
    tick(2);
    set_mode = 1'b1; visible = 1'b1; set_select = 1'b0;
    increase_key = 1'b1;
    tick(6);
    check("latency_before", 32'(minutes), 0);
    tick(1);
    check("latency_at", 32'(minutes), 1);
    tick(13);
    check("hold_minutes", 32'(minutes), 1);
    check("hold_hours", 32'(hours), 10);
    increase_key = 1'b0;
    tick(12);
    check("release_minutes", 32'(minutes), 1);
    #2 reset = 1'b1;
    #1;
    check("async_hours", 32'(hours), 10);
    check("async_minutes", 32'(minutes), 0);
    @(negedge clk) reset = 1'b0;
    tick(2);
    set_select = 1'b1;
    for (int i = 0; i < 13; i++) press(8);
    check("hours_23", 32'(hours), 23);
    press(8);
    check("hours_wrap", 32'(hours), 0);
    set_select = 1'b0;
    for (int i = 0; i < 59; i++) press(8);
    check("minutes_59", 32'(minutes), 59);
    press(8);
    check("minutes_wrap", 32'(minutes), 0);
    check("no_carry", 32'(hours), 0);
    for (int i = 0; i < 10; i++) begin
      increase_key = 1'b1;
      tick(1 + i % 3);
      increase_key = 1'b0;
      tick(2);
    end
    tick(8);
    check("bounce", 32'(minutes), 0);
    press(10);
    check("after_bounce", 32'(minutes), 1);
    set_mode = 1'b0;
    press(10);
    check("mode_off", 32'(minutes), 1);
    set_mode = 1'b1; visible = 1'b0;
    press(10);
    check("hidden", 32'(minutes), 1);
    visible = 1'b1; set_mode = 1'b0;
    increase_key = 1'b1;
    tick(10);
    set_mode = 1'b1;
    tick(10);
    check("late_mode", 32'(minutes), 1);
    increase_key = 1'b0;
    tick(10);
    check("late_release", 32'(minutes), 1);
    press(8);
    check("new_press", 32'(minutes), 2);
    increase_key = 1'b1;
    tick(16);
    check("rpt_pre", 32'(minutes), 3);
    tick(1);
`ifdef TIMER_SETTER_AUTO_REPEAT_EN
    check("rpt_first", 32'(minutes), 4);
    tick(23);
    increase_key = 1'b0;
    tick(15);
    check("rpt_total", 32'(minutes), 9);
`else
    check("rpt_first", 32'(minutes), 3);
    tick(23);
    increase_key = 1'b0;
    tick(15);
    check("rpt_total", 32'(minutes), 3);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
